// File: rtl/exe_pkg.sv
// Shared encodings for the execute/multiply stage: ALU opcodes, FSM states
// and forwarding-source selection.
package exe_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/mdu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle. Bit 0 is
// consumed on the start edge, so the product is complete DATA_W-1 edges later.
module mdu_mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            cnt_d    = CW'(DATA_W);
            acc_d    = b[0] ? a : '0;
            mcand_d  = a << 1;
            mplier_d = b >> 1;
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - CW'(1);
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

    assign busy    = (cnt_q != '0);
    // Final accumulation step happens this cycle; product is valid next cycle.
    assign done    = (cnt_q == CW'(2));
    assign product = acc_q;

endmodule

// File: rtl/exe_mdu_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and a stalling
// iterative multiplier feeding the EX/MEM pipeline registers.
module exe_mdu_stage
    import exe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        alu_op,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic [REG_AW-1:0] dest,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] st_val,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              mem_wb_en,
    input  logic              wb_wb_en,
    input  logic [DATA_W-1:0] mem_fwd,
    input  logic [DATA_W-1:0] wb_fwd,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic [DATA_W-1:0] ex_result,
    output logic [DATA_W-1:0] ex_st_val,
    output logic [REG_AW-1:0] ex_dest
);

    function automatic fwd_sel_e fwd_sel_f(input logic [REG_AW-1:0] src);
        if (mem_wb_en && mem_dest == src && src != '0) return FWD_MEM;
        if (wb_wb_en && wb_dest == src && src != '0)   return FWD_WB;
        return FWD_REG;
    endfunction

    function automatic logic [DATA_W-1:0] fwd_mux_f(input fwd_sel_e sel,
                                                    input logic [DATA_W-1:0] reg_val);
        case (sel)
            FWD_MEM: return mem_fwd;
            FWD_WB:  return wb_fwd;
            default: return reg_val;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [SH_W-1:0]          sh;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return {{(DATA_W-1){1'b0}}, (sa < sb)};
            OP_SLTU: return {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return DATA_W'(sa >>> sh);
            default: return '0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic              ex_valid_q, ex_valid_d;
    logic              ex_wb_en_q, ex_wb_en_d;
    logic              ex_mem_r_en_q, ex_mem_r_en_d;
    logic              ex_mem_w_en_q, ex_mem_w_en_d;
    logic [DATA_W-1:0] ex_result_q, ex_result_d;
    logic [DATA_W-1:0] ex_st_val_q, ex_st_val_d;
    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;

    logic [DATA_W-1:0] op1, op2, st_fwd, alu_res;
    logic              mul_start, mul_busy, mul_done, stall_c;
    logic [DATA_W-1:0] mul_product;

    assign op1     = fwd_mux_f(fwd_sel_f(src1), val1);
    assign op2     = fwd_mux_f(fwd_sel_f(src2), val2);
    assign st_fwd  = fwd_mux_f(fwd_sel_f(src2), st_val);
    assign alu_res = alu_f(alu_op, op1, op2);

    mdu_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op1),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d       = state_q;
        mul_start     = 1'b0;
        stall_c       = 1'b0;
        ex_valid_d    = 1'b0;
        ex_wb_en_d    = 1'b0;
        ex_mem_r_en_d = 1'b0;
        ex_mem_w_en_d = 1'b0;
        ex_result_d   = ex_result_q;
        ex_st_val_d   = ex_st_val_q;
        ex_dest_d     = ex_dest_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && alu_op == OP_MUL) begin
                        mul_start = 1'b1;
                        stall_c   = 1'b1;
                        state_d   = ST_MUL;
                    end else if (in_valid) begin
                        ex_valid_d    = 1'b1;
                        ex_wb_en_d    = wb_en;
                        ex_mem_r_en_d = mem_r_en;
                        ex_mem_w_en_d = mem_w_en;
                        ex_result_d   = alu_res;
                        ex_st_val_d   = st_fwd;
                        ex_dest_d     = dest;
                    end
                end
                ST_MUL: begin
                    stall_c = 1'b1;
                    if (mul_done) state_d = ST_DONE;
                end
                ST_DONE: begin
                    // Upstream is still holding the MUL instruction this cycle.
                    ex_valid_d    = 1'b1;
                    ex_wb_en_d    = wb_en;
                    ex_mem_r_en_d = mem_r_en;
                    ex_mem_w_en_d = mem_w_en;
                    ex_result_d   = mul_product;
                    ex_st_val_d   = st_fwd;
                    ex_dest_d     = dest;
                    state_d       = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ex_valid_q    <= 1'b0;
            ex_wb_en_q    <= 1'b0;
            ex_mem_r_en_q <= 1'b0;
            ex_mem_w_en_q <= 1'b0;
            ex_result_q   <= '0;
            ex_st_val_q   <= '0;
            ex_dest_q     <= '0;
        end else begin
            state_q       <= state_d;
            ex_valid_q    <= ex_valid_d;
            ex_wb_en_q    <= ex_wb_en_d;
            ex_mem_r_en_q <= ex_mem_r_en_d;
            ex_mem_w_en_q <= ex_mem_w_en_d;
            ex_result_q   <= ex_result_d;
            ex_st_val_q   <= ex_st_val_d;
            ex_dest_q     <= ex_dest_d;
        end
    end

    // stall is combinational, so it must be masked while reset is held.
    assign stall       = stall_c & ~rst;
    assign ex_valid    = ex_valid_q;
    assign ex_wb_en    = ex_wb_en_q;
    assign ex_mem_r_en = ex_mem_r_en_q;
    assign ex_mem_w_en = ex_mem_w_en_q;
    assign ex_result   = ex_result_q;
    assign ex_st_val   = ex_st_val_q;
    assign ex_dest     = ex_dest_q;

    logic unused_busy;
    assign unused_busy = mul_busy;

endmodule
